// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a Z80-style flag register F.
// Single-cycle ops complete on the edge that accepts start. Rotates and shifts (opcodes A-D)
// with a non-zero count n move one bit per cycle. They hold busy for n cycles and pulse done
// when the last bit has moved.
// Optional build macro: ALU_SEQ_DAA_EN turns opcode F into DAA. Without it, opcode F is a NOP.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start_i         request, accepted only while busy_o=0
//   opcode_i        operation select
//   a_i, b_i        operands; for shifts b_i[CNT_W-1:0] is the bit count
//   flags_load_i    load flags_in_i into F when idle and start_i=0
//   flags_in_i      external F value {S,Z,H,PV,N,C}
//   result_o        registered result, held until the next completion
//   flags_o         flag register F {S,Z,H,PV,N,C}
//   busy_o          iterative op in progress
//   done_o          one-cycle pulse in the cycle result_o/flags_o update
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flags_load_i,
  input  logic [5:0]       flags_in_i,
  output logic [WIDTH-1:0] result_o,
  output logic [5:0]       flags_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  localparam logic [3:0] OpAdd = 4'h0, OpAdc = 4'h1, OpSub = 4'h2, OpSbc = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4, OpXor = 4'h5, OpOr  = 4'h6, OpCp  = 4'h7;
  localparam logic [3:0] OpInc = 4'h8, OpDec = 4'h9, OpRlc = 4'hA, OpRrc = 4'hB;
  localparam logic [3:0] OpSla = 4'hC, OpSrl = 4'hD, OpPass = 4'hE, OpExt = 4'hF;

  // Bit positions inside F
  localparam int unsigned FlH = 3, FlN = 1, FlC = 0;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [5:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;

  // Flags for logic ops and shifts: parity in PV, N always 0
  function automatic logic [5:0] logic_flags(input logic [WIDTH-1:0] r, input logic h,
                                             input logic c);
    return {r[WIDTH-1], ~|r, h, ~^r, 1'b0, c};
  endfunction

  // Shared WIDTH+1 bit adder/subtractor for ADD..SBC, CP, INC, DEC
  logic             is_sub, cin, ovf;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   arith;
  logic [4:0]       nib;
  logic [5:0]       arith_flags;

  always_comb begin
    op_b   = b_i;
    cin    = 1'b0;
    is_sub = 1'b0;
    case (opcode_i)
      OpAdc:        cin = flags_q[FlC];
      OpSub, OpCp:  is_sub = 1'b1;
      OpSbc: begin
        is_sub = 1'b1;
        cin    = flags_q[FlC];
      end
      OpInc:        op_b = WIDTH'(1);
      OpDec: begin
        op_b   = WIDTH'(1);
        is_sub = 1'b1;
      end
      default: ;
    endcase
    if (is_sub) begin
      arith = {1'b0, a_i} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};
      nib   = {1'b0, a_i[3:0]} - {1'b0, op_b[3:0]} - {4'b0, cin};
      ovf   = (a_i[WIDTH-1] ^ op_b[WIDTH-1]) & (arith[WIDTH-1] ^ a_i[WIDTH-1]);
    end else begin
      arith = {1'b0, a_i} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
      nib   = {1'b0, a_i[3:0]} + {1'b0, op_b[3:0]} + {4'b0, cin};
      ovf   = ~(a_i[WIDTH-1] ^ op_b[WIDTH-1]) & (arith[WIDTH-1] ^ a_i[WIDTH-1]);
    end
    // bit 8 of the extended result is carry for add and borrow for subtract
    arith_flags = {arith[WIDTH-1], ~|arith[WIDTH-1:0], nib[4], ovf, is_sub, arith[WIDTH]};
  end

  // One step of the iterative rotate/shift; kind is opcode[1:0]
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;

  always_comb begin
    case (kind_q)
      2'b10: begin  // RLC
        sh_nxt = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
        sh_out = sh_q[WIDTH-1];
      end
      2'b11: begin  // RRC
        sh_nxt = {sh_q[0], sh_q[WIDTH-1:1]};
        sh_out = sh_q[0];
      end
      2'b00: begin  // SLA
        sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
        sh_out = sh_q[WIDTH-1];
      end
      default: begin  // SRL
        sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
        sh_out = sh_q[0];
      end
    endcase
  end

`ifdef ALU_SEQ_DAA_EN
  logic [7:0] daa_corr, daa_res;
  logic       daa_c, daa_h;

  always_comb begin
    daa_corr = 8'h00;
    daa_c    = flags_q[FlC];
    if (flags_q[FlH] || (a_i[3:0] > 4'd9)) daa_corr[3:0] = 4'h6;
    if (flags_q[FlC] || (a_i[7:0] > 8'h99)) begin
      daa_corr[7:4] = 4'h6;
      daa_c         = 1'b1;
    end
    daa_res = flags_q[FlN] ? (a_i[7:0] - daa_corr) : (a_i[7:0] + daa_corr);
    daa_h   = flags_q[FlN] ? (flags_q[FlH] && (a_i[3:0] < 4'd6)) : (a_i[3:0] > 4'd9);
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          done_d = 1'b1;
          case (opcode_i)
            OpAdd, OpAdc, OpSub, OpSbc: begin
              result_d = arith[WIDTH-1:0];
              flags_d  = arith_flags;
            end
            OpCp: flags_d = arith_flags;
            OpInc, OpDec: begin
              result_d = arith[WIDTH-1:0];
              flags_d  = {arith_flags[5:1], flags_q[FlC]};
            end
            OpAnd: begin
              result_d = a_i & b_i;
              flags_d  = logic_flags(a_i & b_i, 1'b1, 1'b0);
            end
            OpXor: begin
              result_d = a_i ^ b_i;
              flags_d  = logic_flags(a_i ^ b_i, 1'b0, 1'b0);
            end
            OpOr: begin
              result_d = a_i | b_i;
              flags_d  = logic_flags(a_i | b_i, 1'b0, 1'b0);
            end
            OpRlc, OpRrc, OpSla, OpSrl: begin
              if (b_i[CNT_W-1:0] == '0) begin
                result_d = a_i;
                flags_d  = logic_flags(a_i, 1'b0, flags_q[FlC]);
              end else begin
                state_d = StShift;
                sh_d    = a_i;
                cnt_d   = b_i[CNT_W-1:0];
                kind_d  = opcode_i[1:0];
                done_d  = 1'b0;
              end
            end
            OpPass: result_d = b_i;
`ifdef ALU_SEQ_DAA_EN
            OpExt: begin
              result_d = WIDTH'(daa_res);
              flags_d  = {1'b0, 1'b0, daa_h, ~^daa_res, flags_q[FlN], daa_c};
              flags_d[5] = result_d[WIDTH-1];
              flags_d[4] = ~|daa_res;
            end
`else
            OpExt: ;  // NOP: completes with result and F untouched
`endif
            default: ;
          endcase
        end else if (flags_load_i) begin
          flags_d = flags_in_i;
        end
      end
      StShift: begin
        sh_d  = sh_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = sh_nxt;
          flags_d  = logic_flags(sh_nxt, 1'b0, sh_out);
          state_d  = StIdle;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
    end
  end

  assign result_o = result_q;
  assign flags_o  = flags_q;
  assign busy_o   = (state_q == StShift);
  assign done_o   = done_q;

endmodule
